adder_nbit_serial: RTL
======================

Name: adder_nbit_serial

Overview:
Parametrised multi-cycle ripple adder, successor to the 1-bit full adder cell. It adds two WIDTH-bit operands CHUNK bits per clock using a chain of CHUNK full-adder cells and a registered inter-chunk carry. It is used wherever a wide add must trade latency for area. It has a start/busy/done handshake, a registered result, and carry-out and signed-overflow flags.

Parameters:
WIDTH, 16, operand and result width in bits; must be >= 1.
CHUNK, 4, bits added per clock; 1 <= CHUNK <= WIDTH; WIDTH must be a multiple of CHUNK. NCHUNK = WIDTH/CHUNK.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous reset, active-high.
start  in  1  request; sampled on a rising edge while state is IDLE or DONE.
a  in  WIDTH  operand A; captured on an accepted start.
b  in  WIDTH  operand B; captured on an accepted start.
carry_in  in  1  initial carry; captured on an accepted start.
busy  out  1  high while state is RUN.
done  out  1  one-cycle pulse; high while state is DONE.
sum  out  WIDTH  registered result; holds the last completed value.
carry_out  out  1  carry out of bit WIDTH-1 of the last completed add.
overflow  out  1  signed overflow of the last completed add.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE; busy=0, done=0, sum=0, carry_out=0, overflow=0; operand, partial-sum and carry registers and chunk counter all cleared.
- States:
  - IDLE: waits for start.
  - RUN: processes one chunk per cycle.
  - DONE: presents done for one cycle.
- IDLE -> RUN on a rising edge with start=1. That edge captures a, b and carry_in, and clears the chunk counter.
- RUN, each cycle:
  - Add the low CHUNK bits of the operand shift registers plus the carry register.
  - Shift the CHUNK result bits into the internal partial-sum register from the MSB end.
  - Shift the operands right by CHUNK.
  - Register the chunk carry and increment the counter.
- RUN -> DONE on the edge that completes chunk NCHUNK-1. That same edge loads sum from the internal register, loads carry_out with the final carry, and loads overflow = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
- DONE -> RUN if start=1, with a new capture (back-to-back operation). Otherwise DONE -> IDLE.
- Latency: start is high in cycle 0. busy is high in cycles 1..NCHUNK. done is high in cycle NCHUNK+1. sum and flags are valid from cycle NCHUNK+1 until the next completion.
- start while in RUN is ignored; the operation in flight is unaffected, and a/b changes during RUN have no effect.
- sum, carry_out and overflow stay stable during RUN; they change only on the RUN->DONE edge.
- CHUNK=WIDTH: NCHUNK=1; a single RUN cycle, then done in cycle 2.
- Arithmetic is modulo 2^WIDTH.
- rst asserted mid-RUN: the operation is abandoned immediately; no done pulse; outputs return to their reset values.

Optional Feature:
ADDER_NBIT_SUB_EN:
- Defined: adds input port sub (in, 1), captured on an accepted start. When sub=1, the block captures ~b and forces the initial carry to 1, so the result is a-b; carry_in is ignored. carry_out=1 means no borrow. overflow uses the same rule.
- Undefined: no sub port; the block is add-only.

Test Plan:
1. WIDTH=16, CHUNK=4; a=0x1234, b=0x4321, carry_in=0, start in cycle 0 -> busy cycles 1-4, done in cycle 5 only; sum=0x5555, carry_out=0, overflow=0.
2. a=0xFFFF, b=0x0001, carry_in=0 -> sum=0x0000, carry_out=1, overflow=0. Then a=0x7FFF, b=0x0001 -> sum=0x8000, carry_out=0, overflow=1.
3. a=0x00FF, b=0x0000, carry_in=1; pulse start again in cycles 2 and 3 with other operands -> those starts are ignored; single done in cycle 5; sum=0x0100. sum holds the previous result through cycles 1-4.
4. Back-to-back: start held high through the DONE cycle with a=0x0002, b=0x0003 -> second busy in cycles 6-9, done in cycle 10, sum=0x0005.
5. Reset mid-op: rst pulsed in cycle 2 of a run -> busy=0, sum=0 immediately; no done. A fresh start afterwards completes normally.
6. ADDER_NBIT_SUB_EN defined; sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, carry_out=0, overflow=0. With sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, carry_out=1, overflow=1.

Source files
------------

// File: rtl/adder_nbit_serial.sv
`default_nettype none
// ============================================================================
//  Module   : adder_nbit_serial
//  Purpose  : Multi-cycle WIDTH-bit ripple adder. Each clock, a chain of
//             CHUNK full-adder cells adds the low CHUNK bits of two operand
//             shift registers and the registered inter-chunk carry. After
//             NCHUNK = WIDTH/CHUNK cycles the result and the carry-out and
//             signed-overflow flags are loaded into output registers.
//
//  Ports    : clk        system clock, rising edge
//             rst        asynchronous reset, active-high
//             start      request; accepted while IDLE or DONE
//             a, b       operands, captured on an accepted start
//             carry_in   initial carry, captured on an accepted start
//             sub        (ADDER_NBIT_SUB_EN only) 1 = compute a - b
//             busy       high while a chunked add is in progress
//             done       one-cycle pulse when a new result is presented
//             sum        registered result of the last completed add
//             carry_out  carry out of bit WIDTH-1 of the last completed add
//             overflow   signed overflow of the last completed add
//
//  Options  : ADDER_NBIT_SUB_EN - when defined, adds the sub input. With
//             sub=1 the block captures ~b and forces the initial carry to 1
//             (carry_in is ignored), yielding a - b; carry_out=1 means no
//             borrow.
//
//  Revision : 1.0 - initial release
// ============================================================================
module adder_nbit_serial #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
`ifdef ADDER_NBIT_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    // Counter needs at least one bit even when a single chunk covers WIDTH.
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [CW-1:0] c_LAST_CNT = CW'(NCHUNK - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_b_cap;
    logic             w_cin_cap;
    logic [CHUNK-1:0] w_s;
    logic [CHUNK:0]   w_c;
    logic [WIDTH-1:0] w_result;

    // ------------------------------------------------------------------------
    // Operand conditioning at capture time
    // ------------------------------------------------------------------------
`ifdef ADDER_NBIT_SUB_EN
    // Two's-complement subtraction: a + ~b + 1.
    assign w_b_cap   = sub ? ~b   : b;
    assign w_cin_cap = sub ? 1'b1 : carry_in;
`else
    assign w_b_cap   = b;
    assign w_cin_cap = carry_in;
`endif

    // A start is only honoured outside RUN; the operation in flight is never
    // disturbed.
    assign w_accept = start && ((r_state == c_IDLE) || (r_state == c_DONE));
    assign w_last   = (r_cnt == c_LAST_CNT);

    // ------------------------------------------------------------------------
    // CHUNK-cell full-adder ripple chain on the low operand bits.
    // w_c[i] is the carry into cell i; w_c[CHUNK] leaves the chunk.
    // ------------------------------------------------------------------------
    always_comb begin
        w_c    = '0;
        w_s    = '0;
        w_c[0] = r_carry;
        for (int i = 0; i < CHUNK; i++) begin
            w_s[i]   = r_a[i] ^ r_b[i] ^ w_c[i];
            w_c[i+1] = (r_a[i] & r_b[i]) | (w_c[i] & (r_a[i] ^ r_b[i]));
        end
    end

    // ------------------------------------------------------------------------
    // Partial-sum register: chunk results enter from the MSB end, so after
    // the last chunk the first chunk has reached the LSBs. The final chunk is
    // combined directly into w_result, so only WIDTH-CHUNK bits need storage.
    // ------------------------------------------------------------------------
    generate
        if (NCHUNK > 1) begin : g_multi
            logic [WIDTH-CHUNK-1:0] r_psum;

            assign w_result = {w_s, r_psum};

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_psum <= '0;
                end else if (w_accept) begin
                    r_psum <= '0;
                end else if (r_state == c_RUN) begin
                    r_psum <= w_result[WIDTH-1:CHUNK];
                end
            end
        end else begin : g_single
            assign w_result = w_s;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Control, operand shift registers, carry, counter and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (w_accept) begin
            r_state <= c_RUN;
            r_a     <= a;
            r_b     <= w_b_cap;
            r_carry <= w_cin_cap;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_RUN: begin
                    r_a     <= r_a >> CHUNK;
                    r_b     <= r_b >> CHUNK;
                    r_carry <= w_c[CHUNK];
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_state   <= c_DONE;
                        sum       <= w_result;
                        carry_out <= w_c[CHUNK];
                        // Signed overflow: carry into MSB differs from carry out.
                        overflow  <= w_c[CHUNK] ^ w_c[CHUNK-1];
                    end
                end
                c_DONE:  r_state <= c_IDLE;
                c_IDLE:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign busy = (r_state == c_RUN);
    assign done = (r_state == c_DONE);

endmodule
`default_nettype wire
